// File: rtl/dmem_responder.sv
// Multi-cycle byte-addressed data memory for the MEM stage: valid/ready request in,
// valid/ready response out after LATENCY cycles, with size/alignment/range error flagging.
module dmem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int WORDS = DEPTH_BYTES / 8;
  localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            accept;
  logic            write_reg;
  logic [63:0]     addr_reg;
  logic [3:0]      size_reg;
  logic [63:0]     wdata_reg;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (count_reg == '0) state_next = RESP;
        else                 count_next = count_reg - 1'b1;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      size_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (accept) begin
        write_reg <= req_write;
        addr_reg  <= req_addr;
        size_reg  <= req_size;
        wdata_reg <= req_wdata;
      end
    end
  end

  // With LATENCY=1 the commit edge is the accept edge, so the live bus is used there.
  logic        cur_write;
  logic [63:0] cur_addr;
  logic [3:0]  cur_size;
  logic [63:0] cur_wdata;
  assign cur_write = (state_reg == IDLE) ? req_write : write_reg;
  assign cur_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
  assign cur_size  = (state_reg == IDLE) ? req_size  : size_reg;
  assign cur_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;

  logic        size_ok;
  logic        misalign;
  logic [64:0] end_addr;
  logic        cur_err;

  always_comb begin
    size_ok  = 1'b0;
    misalign = 1'b0;
    case (cur_size)
      4'd1: size_ok = 1'b1;
      4'd2: begin size_ok = 1'b1; misalign = cur_addr[0];      end
      4'd4: begin size_ok = 1'b1; misalign = |cur_addr[1:0];   end
      4'd8: begin size_ok = 1'b1; misalign = |cur_addr[2:0];   end
      default: ;
    endcase
  end

  assign end_addr = {1'b0, cur_addr} + {61'b0, cur_size};
  assign cur_err  = !size_ok || misalign || (end_addr > 65'(DEPTH_BYTES));

  logic            enter_resp;
  logic            mem_we;
  logic            rd_en;
  logic [2:0]      off;
  logic [WAW-1:0]  word_idx;
  logic [63:0]     wshift;
  logic [63:0]     rd_word;

  assign enter_resp = (state_next == RESP) && (state_reg != RESP);
  assign mem_we     = enter_resp &&  cur_write && !cur_err;
  assign rd_en      = enter_resp && !cur_write && !cur_err;
  assign off        = cur_addr[2:0];
  assign word_idx   = cur_addr[WAW+2:3];
  assign wshift     = cur_wdata << {off, 3'b000};

  // Legal accesses never cross an 8-byte word, so one byte lane per word byte suffices.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      logic [7:0] lane_rd_reg;
      logic       lane_sel;

      assign lane_sel = ({1'b0, off} <= 4'(gi)) && (4'(gi) < ({1'b0, off} + cur_size));

      always_ff @(posedge clk) begin
        if (mem_we && lane_sel) lane_mem[word_idx] <= wshift[8*gi +: 8];
        if (rd_en)              lane_rd_reg        <= lane_mem[word_idx];
      end

      assign rd_word[8*gi +: 8] = lane_rd_reg;
    end
  endgenerate

  logic [63:0] rd_shift;
  logic [63:0] rd_mask;

  assign rd_shift = rd_word >> {addr_reg[2:0], 3'b000};

  always_comb begin
    rd_mask = '1;
    case (size_reg)
      4'd1:    rd_mask = 64'h0000_0000_0000_00FF;
      4'd2:    rd_mask = 64'h0000_0000_0000_FFFF;
      4'd4:    rd_mask = 64'h0000_0000_FFFF_FFFF;
      default: rd_mask = '1;
    endcase
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_err   = resp_valid && cur_err;
  assign resp_rdata = (resp_valid && !write_reg && !cur_err) ? (rd_shift & rd_mask) : '0;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the pipelined CPU's MEM stage. It services byte-addressed load/store requests from the datapath over a valid/ready request channel and returns each result over a valid/ready response channel after a fixed, parameterised latency. It also flags misaligned, out-of-range and illegal-size accesses, so the pipeline can stall on `req_ready`/`resp_valid` instead of relying on a zero-latency memory.

## Interface
- `DEPTH_BYTES`, default 1024: memory size in bytes; must be a power of 2 and at least 8.
- `LATENCY`, default 2: number of cycles from the accept cycle to the first cycle `resp_valid` is high; must be at least 1.
- `clk` input 1: the block uses one clock; all state changes on the rising edge.
- `reset_n` input 1: reset is asynchronous and active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: the block can accept a request this cycle.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input 64: byte address.
- `req_size` input 4: transfer size in bytes; legal values are 1, 2, 4 and 8.
- `req_wdata` input 64: store data; only the low `req_size` bytes are used.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: the consumer takes the response.
- `resp_rdata` output 64: load data, zero-extended; 0 for stores and for errors.
- `resp_err` output 1: the access was rejected and memory was not modified.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - `req_ready` = 1.
  - A request is accepted when `req_valid` and `req_ready` are both high at a rising edge. On that edge the block captures write, addr, size and wdata.
  - If `LATENCY` = 1, go to RESP. Otherwise load the down-counter with `LATENCY`-2 and go to WAIT.
- WAIT
  - `req_ready` = 0.
  - The counter decrements each cycle. At the edge where the counter is 0, go to RESP.
- RESP
  - `req_ready` = 0 and `resp_valid` = 1.
  - `resp_rdata` and `resp_err` are held stable until `resp_ready` is 1 at an edge, then the FSM returns to IDLE.
  - A new request is not accepted in the same cycle as the response handshake.
- Counter width is `$clog2(LATENCY)`, with a minimum of 1 bit.
- Memory commit and read capture happen only on the edge that enters RESP.
- Error check is done on the captured request. `resp_err` = 1 if any of the following holds:
  - `size` is not in {1, 2, 4, 8};
  - `addr` modulo `size` is not 0;
  - `addr` + `size` > `DEPTH_BYTES`. This comparison uses 65-bit arithmetic so that addresses near 2^64 do not wrap.
- On an error: there is no memory write and `resp_rdata` = 0.
- Legal store:
  - `mem[addr+i]` = `wdata[8i+7:8i]` for i = 0 to size-1. The encoding is little-endian.
  - Other bytes are untouched.
  - `resp_rdata` = 0.
- Legal load: `resp_rdata[8i+7:8i]` = `mem[addr+i]` for i < size; all upper bytes are 0.
- Memory contents are not reset. Contents are undefined until written; the bench must write before reading.

## Timing
- Reset values: `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, FSM = IDLE, counter = 0.
- Response latency: if the accept edge is E0, `resp_valid` rises at edge E0+`LATENCY`-1 and is visible in cycle E0+`LATENCY`. Throughput is at most one request per `LATENCY`+1 cycles.
- Back-pressure: `resp_valid` stays high for as long as `resp_ready` stays low, for any number of cycles. `resp_rdata` and `resp_err` do not change during that time.
- Inputs `req_*` are ignored when `req_ready` = 0. Changes to them during WAIT or RESP have no effect.
- Reset asserted mid-operation:
  - The FSM returns to IDLE immediately and any in-flight response is dropped.
  - If reset arrives before the commit edge, the store is not performed.
  - A store that was already committed remains in memory.
- `resp_valid` and `req_ready` are never 1 in the same cycle.

## Test plan
- With `LATENCY` = 2: store size 8, addr 0x10, data 0x0123456789ABCDEF, then load size 8 from 0x10.
  - Required: `resp_rdata` = 0x0123456789ABCDEF and `resp_err` = 0.
  - Required: `resp_valid` is first high exactly 2 cycles after each accept cycle.
- Byte merge: after the previous test, store size 1 to 0x12 with data 0xFF, then load size 8 from 0x10.
  - Required: `resp_rdata` = 0x0123456789FFCDEF.
- Narrow load: load size 2 from 0x14.
  - Required: `resp_rdata` = 0x0000000000004567.
- Errors, each required to give `resp_err` = 1 and `resp_rdata` = 0:
  - store size 4 to 0x12 (misaligned); a following load of 0x10 must be unchanged;
  - load size 8 from 1020 with `DEPTH_BYTES` = 1024 (out of range);
  - `req_size` = 3 (illegal size).
- Back-pressure: hold `resp_ready` = 0 for 5 cycles during a load.
  - Required: `resp_valid`, `resp_rdata` and `req_ready` = 0 are all stable for those 5 cycles.
  - Required: after `resp_ready` is raised, `req_ready` = 1 in the next cycle.
- Reset mid-operation: with `LATENCY` = 4, issue a store of 0xAA to 0x20 and drop `reset_n` for 1 cycle during WAIT.
  - Required: `resp_valid` never asserts and outputs are at reset values.
  - Required: a later load of 0x20 returns the prior contents, not 0xAA.
